// File: rtl/down_counter_timer_arbiter.sv
// Round-robin timer arbiter: several requesters share one down counter.
// A grant loads that requester's interval, counts it down to zero, then pulses DONE.
module down_counter_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  C,
    input  logic                  CLR,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] LEN,
    input  logic                  ABORT,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       DONE,
    output logic                  BUSY,
    output logic [WIDTH-1:0]      CNT
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     g_q, g_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;

    logic [IW-1:0]     sel;
    logic              found;
    int                scanIdx;

    function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    // First requesting index at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        sel     = '0;
        found   = 1'b0;
        scanIdx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scanIdx = int'(ptr_q) + k;
            if (scanIdx >= NREQ) begin
                scanIdx = scanIdx - NREQ;
            end
            if (!found && REQ[IW'(scanIdx)]) begin
                found = 1'b1;
                sel   = IW'(scanIdx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = RUN;
                    g_d        = sel;
                    cnt_d      = LEN[int'(sel)*WIDTH +: WIDTH];
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                if (ABORT) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = nextIdx(g_q);
                end else if (cnt_q == '0) begin
                    state_d     = FIN;
                    gnt_d       = '0;
                    done_d      = '0;
                    done_d[g_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = '0;
                busy_d  = 1'b0;
                ptr_d   = nextIdx(g_q);
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                done_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT  = gnt_q;
    assign DONE = done_q;
    assign BUSY = busy_q;
    assign CNT  = cnt_q;

endmodule

// File: tb/tb_down_counter_timer_arbiter.sv
// Directed bench for down_counter_timer_arbiter (NREQ=4, WIDTH=4) with
// hand-computed expectations checked by immediate assertions.
module tb_down_counter_timer_arbiter;

    logic        C;
    logic        CLR;
    logic [3:0]  REQ;
    logic [15:0] LEN;
    logic        ABORT;
    logic [3:0]  GNT;
    logic [3:0]  DONE;
    logic        BUSY;
    logic [3:0]  CNT;

    int passCount = 0;
    int failCount = 0;
    int totalCount = 0;

    down_counter_timer_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .C     (C),
        .CLR   (CLR),
        .REQ   (REQ),
        .LEN   (LEN),
        .ABORT (ABORT),
        .GNT   (GNT),
        .DONE  (DONE),
        .BUSY  (BUSY),
        .CNT   (CNT)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    // Advance to just after the next rising edge so outputs have settled.
    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] eGnt, input logic [3:0] eDone,
                            input logic eBusy, input logic [3:0] eCnt);
        checkOutput({tag, ".gnt"},  32'(GNT),  32'(eGnt));
        checkOutput({tag, ".done"}, 32'(DONE), 32'(eDone));
        checkOutput({tag, ".busy"}, 32'(BUSY), 32'(eBusy));
        checkOutput({tag, ".cnt"},  32'(CNT),  32'(eCnt));
    endtask

    task automatic pulseClear();
        CLR = 1'b1;
        #2;
        CLR = 1'b0;
    endtask

    initial begin
        logic [3:0] expCnt;
        logic [3:0] expGnt;
        CLR   = 1'b1;
        REQ   = '0;
        LEN   = '0;
        ABORT = 1'b0;
        #3;
        checkAll("reset", 4'b0000, 4'b0000, 1'b0, 4'd0);
        #4;
        CLR = 1'b0;
        tick();

        // Single request, LEN0 = 3
        REQ = 4'b0001;
        LEN[3:0] = 4'd3;
        expCnt = 4'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkAll("single.run", 4'b0001, 4'b0000, 1'b1, expCnt);
            expCnt = expCnt - 4'd1;
        end
        tick();
        checkAll("single.done", 4'b0000, 4'b0001, 1'b1, 4'd0);
        REQ = 4'b0000;
        tick();
        checkAll("single.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

        // Zero length on requester 2 (pointer now 1)
        REQ = 4'b0100;
        LEN[11:8] = 4'd0;
        tick();
        checkAll("zero.run", 4'b0100, 4'b0000, 1'b1, 4'd0);
        tick();
        checkAll("zero.done", 4'b0000, 4'b0100, 1'b1, 4'd0);
        REQ = 4'b0000;
        tick();
        checkAll("zero.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

        // Round robin with all requests held, all LEN = 1, pointer reset to 0
        pulseClear();
        LEN = 16'h1111;
        REQ = 4'b1111;
        ABORT = 1'b1;
        for (int n = 0; n < 5; n++) begin
            expGnt = 4'b0001 << (n % 4);
            tick();
            ABORT = 1'b0;
            checkAll("rr.first", expGnt, 4'b0000, 1'b1, 4'd1);
            tick();
            checkAll("rr.second", expGnt, 4'b0000, 1'b1, 4'd0);
            tick();
            checkAll("rr.fin", 4'b0000, expGnt, 1'b1, 4'd0);
            tick();
            checkAll("rr.gap", 4'b0000, 4'b0000, 1'b0, 4'd0);
        end
        REQ = 4'b0000;

        // Abort on requester 1 when CNT = 10 (pointer now 1)
        REQ = 4'b0010;
        LEN[7:4] = 4'd15;
        tick();
        checkAll("abort.load", 4'b0010, 4'b0000, 1'b1, 4'd15);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkAll("abort.at10", 4'b0010, 4'b0000, 1'b1, 4'd10);
        ABORT = 1'b1;
        REQ = 4'b0011;
        tick();
        ABORT = 1'b0;
        checkAll("abort.drop", 4'b0000, 4'b0000, 1'b0, 4'd10);
        tick();
        checkAll("abort.next", 4'b0001, 4'b0000, 1'b1, 4'd1);
        tick();
        checkAll("abort.next0", 4'b0001, 4'b0000, 1'b1, 4'd0);
        tick();
        checkAll("abort.nextdone", 4'b0000, 4'b0001, 1'b1, 4'd0);
        REQ = 4'b0000;
        tick();
        checkAll("abort.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

        // Mid-run changes on requester 3 (pointer now 1)
        REQ = 4'b1000;
        LEN[15:12] = 4'd5;
        tick();
        checkAll("mid.load", 4'b1000, 4'b0000, 1'b1, 4'd5);
        LEN[15:12] = 4'd1;
        REQ = 4'b1001;
        expCnt = 4'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkAll("mid.run", 4'b1000, 4'b0000, 1'b1, expCnt);
            expCnt = expCnt - 4'd1;
        end
        tick();
        checkAll("mid.done", 4'b0000, 4'b1000, 1'b1, 4'd0);
        REQ = 4'b0001;
        tick();
        checkAll("mid.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);
        tick();
        checkAll("mid.req0", 4'b0001, 4'b0000, 1'b1, 4'd1);
        tick();
        tick();
        checkAll("mid.req0done", 4'b0000, 4'b0001, 1'b1, 4'd0);
        REQ = 4'b0000;
        tick();

        // Async clear mid-run while CNT = 7 (pointer now 1, grant goes to 2)
        REQ = 4'b0100;
        LEN[11:8] = 4'd9;
        tick();
        checkAll("clr.load", 4'b0100, 4'b0000, 1'b1, 4'd9);
        tick();
        tick();
        checkAll("clr.at7", 4'b0100, 4'b0000, 1'b1, 4'd7);
        #3;
        CLR = 1'b1;
        #1;
        checkAll("clr.async", 4'b0000, 4'b0000, 1'b0, 4'd0);
        REQ = 4'b1111;
        LEN = 16'h1111;
        #1;
        CLR = 1'b0;
        tick();
        checkAll("clr.firstgrant", 4'b0001, 4'b0000, 1'b1, 4'd1);
        tick();
        tick();
        checkAll("clr.nodone2", 4'b0000, 4'b0001, 1'b1, 4'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/down_counter_timer_arbiter.md
# down_counter_timer_arbiter

Round-robin scheduler that shares one WIDTH-bit down counter among NREQ requesters, each asking for a timed interval. The block picks a requester, loads the counter with that requester's interval length, counts down to zero, then pulses that requester's DONE. It sits between the requesting control blocks and the shared down-count datapath and owns all sequencing of that counter.

## Interface
- NREQ, 4: number of requesters; range 2..8.
- WIDTH, 4: counter and interval-length width.
- C  input  1  clock; rising edge active.
- CLR  input  1  asynchronous clear, active-high; all state returns to reset values immediately.
- REQ  input  NREQ  per-requester request level; bit i belongs to requester i.
- LEN  input  NREQ*WIDTH  per-requester interval; requester i uses LEN[i*WIDTH +: WIDTH], unsigned.
- ABORT  input  1  cancels the interval in progress.
- GNT  output  NREQ  one-hot grant; all zero when no interval is running.
- DONE  output  NREQ  one-cycle completion pulse to the granted requester; at most one bit set.
- BUSY  output  1  high whenever state is not IDLE.
- CNT  output  WIDTH  current shared counter value.

## Operation
- State machine with three states: IDLE, RUN, FIN. All outputs are registered.
- Reset values: state IDLE, CNT = 0, GNT = 0, DONE = 0, BUSY = 0, round-robin pointer PTR = 0.
- IDLE:
  - If REQ == 0, remain in IDLE.
  - Otherwise select g = the first index with REQ[g] = 1, scanning PTR, PTR+1, … modulo NREQ.
  - On the next edge: latch g, set CNT <= LEN slice g, set GNT <= one-hot(g), and go to RUN.
- RUN:
  - If ABORT = 1: go to IDLE. GNT <= 0, no DONE pulse, PTR <= (g+1) mod NREQ, CNT holds its value.
  - Else if CNT == 0: go to FIN, set GNT <= 0 and DONE[g] <= 1.
  - Else CNT <= CNT - 1. The decrement is unsigned modulo 2^WIDTH, but CNT is never decremented from 0.
- FIN:
  - DONE <= 0 and PTR <= (g+1) mod NREQ; go to IDLE.
  - ABORT is ignored in FIN.
- ABORT is also ignored in IDLE.
- Intervals are non-preemptive:
  - A change in REQ during RUN or FIN has no effect.
  - LEN is sampled only at the grant edge; later LEN changes have no effect on the running interval.
- A requester keeps REQ high until it sees DONE. A REQ still high after DONE is eligible again, but behind all other requesters.
- LEN = 0 is legal and gives a RUN phase of one cycle.
- LEN = 2^WIDTH-1 gives the maximum interval. No wrap occurs.

## Timing
- Arbitration latency: if REQ is sampled in IDLE at edge k, GNT[g] is high and CNT = LEN[g] starting after edge k.
- GNT[g] stays high for exactly LEN[g]+1 cycles. CNT shows the values LEN, LEN-1, …, 0, one per cycle.
- DONE[g] is high for exactly one cycle, the cycle immediately after GNT falls. BUSY stays high during that cycle.
- Back-to-back intervals: the cycle after DONE is spent in IDLE with BUSY = 0. The next GNT rises one edge later, so there is a 2-cycle gap between GNT falling and the next GNT rising.
- ABORT sampled high at edge k during RUN: GNT and BUSY are low after edge k and DONE never pulses. A new grant can follow at edge k+1.
- CLR asserted at any time, including mid-RUN or in FIN:
  - Outputs reach their reset values without waiting for a clock edge.
  - No DONE pulse is emitted for the interrupted interval.
  - The first grant after CLR deasserts uses PTR = 0.
- Fairness: with all REQ held high, grants rotate 0, 1, …, NREQ-1, 0, … with no requester skipped.

## Test plan
- Single request: CLR pulse; REQ = 0001, LEN0 = 3.
  - Required response: GNT = 0001 for 4 cycles with CNT = 3,2,1,0, then DONE = 0001 for 1 cycle, then BUSY = 0.
- Zero length: REQ = 0100, LEN2 = 0.
  - Required response: GNT = 0100 for 1 cycle with CNT = 0, DONE = 0100 on the next cycle.
- Round-robin: REQ = 1111 held, all LEN = 1.
  - Required response: grant order 0, 1, 2, 3, 0; each GNT lasts 2 cycles; 2-cycle gap between consecutive GNTs.
- Abort: REQ = 0010, LEN1 = 15, ABORT pulsed for 1 cycle when CNT = 10.
  - Required response: GNT drops after that edge, CNT holds 10, no DONE. With REQ = 0011 held, the next grant goes to requester 2 or later in scan order, i.e. requester 0 here.
- Mid-run changes: during RUN of requester 3 (LEN3 = 5), change LEN3 to 1 and raise REQ0.
  - Required response: CNT still counts 5 down to 0; requester 0 is granted only after DONE = 1000 has pulsed.
- Async reset: assert CLR between clock edges while CNT = 7 in RUN.
  - Required response: GNT = 0, CNT = 0, BUSY = 0 before the next edge. After release with REQ = 1111, requester 0 is granted first.
